// File: rtl/stream_packer.sv
// stream_packer: narrow-to-wide valid/ready packer. Gathers LANES beats of
// DATAW bits into one wide word with per-lane keep and frame-last marking.
// A frame ending early (last_in) produces a short word with upper lanes zero.
// Optional feature: define STREAM_PACKER_STATS_EN to add a 16-bit frame_count
// output that counts popped words carrying last_out (wraps at 0xFFFF).
module stream_packer #(
  parameter int unsigned DATAW = 8,
  parameter int unsigned LANES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_in,
  input  logic [DATAW-1:0]       data_in,
  input  logic                   last_in,
  output logic                   ready_in,
  output logic                   valid_out,
  output logic [DATAW*LANES-1:0] data_out,
  output logic [LANES-1:0]       keep_out,
  output logic                   last_out,
  input  logic                   ready_out
`ifdef STREAM_PACKER_STATS_EN
  ,
  output logic [15:0]            frame_count
`endif
);

  localparam int unsigned IDXW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned ACCL = LANES - 1;

  typedef enum logic {FILL, HOLD} state_t;

  state_t                        state_q, state_d;
  logic [IDXW-1:0]               idx_q, idx_d;
  logic [ACCL-1:0][DATAW-1:0]    acc_q, acc_d;
  logic [ACCL-1:0]               akeep_q, akeep_d;

  logic [LANES-1:0][DATAW-1:0]   dout_q;
  logic [LANES-1:0]              keep_q;
  logic                          last_q;

  logic [LANES-1:0][DATAW-1:0]   word_c;
  logic [LANES-1:0]              wkeep_c;
  logic                          push_c;
  logic                          pop_c;
  logic                          complete_c;

  // Handshakes; a held word blocks input unless it leaves this cycle
  assign valid_out  = (state_q == HOLD);
  assign ready_in   = !valid_out || ready_out;
  assign push_c     = valid_in && ready_in;
  assign pop_c      = valid_out && ready_out;
  assign complete_c = (idx_q == IDXW'(ACCL)) || last_in;

  assign data_out = dout_q;
  assign keep_out = keep_q;
  assign last_out = last_q;

  // Assemble the outgoing word: filled lanes from acc, current beat at idx, rest zero
  always_comb begin
    word_c  = '0;
    wkeep_c = '0;
    for (int unsigned k = 0; k < ACCL; k++) begin
      word_c[k]  = akeep_q[k] ? acc_q[k] : '0;
      wkeep_c[k] = akeep_q[k];
    end
    for (int unsigned k = 0; k < LANES; k++) begin
      if (IDXW'(k) == idx_q) begin
        word_c[k]  = data_in;
        wkeep_c[k] = 1'b1;
      end
    end
  end

  // Next-state: lane accumulation and FILL/HOLD transitions
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    akeep_d = akeep_q;
    if (push_c && complete_c) begin
      idx_d   = '0;
      acc_d   = '0;
      akeep_d = '0;
      state_d = HOLD;
    end else begin
      if (push_c) begin
        for (int unsigned k = 0; k < ACCL; k++) begin
          if (IDXW'(k) == idx_q) begin
            acc_d[k]   = data_in;
            akeep_d[k] = 1'b1;
          end
        end
        idx_d = idx_q + IDXW'(1);
      end
      if (pop_c) begin
        state_d = FILL;
      end
    end
  end

  // State and accumulator registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      idx_q   <= '0;
      acc_q   <= '0;
      akeep_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      akeep_q <= akeep_d;
    end
  end

  // Output word register, loaded on a completing push and held otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q <= '0;
      keep_q <= '0;
      last_q <= 1'b0;
    end else if (push_c && complete_c) begin
      dout_q <= word_c;
      keep_q <= wkeep_c;
      last_q <= last_in;
    end
  end

`ifdef STREAM_PACKER_STATS_EN
  // Count frames leaving the packer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_count <= '0;
    end else if (pop_c && last_q) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_packer.sv
// tb_stream_packer: scoreboard bench for stream_packer with a frame-level
// reference model, directed test-plan cases and randomized traffic.
module tb_stream_packer;

  localparam int unsigned DATAW = 8;
  localparam int unsigned LANES = 4;
  localparam int unsigned WW    = DATAW * LANES;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             valid_in;
  logic [DATAW-1:0] data_in;
  logic             last_in;
  logic             ready_in;
  logic             valid_out;
  logic [WW-1:0]    data_out;
  logic [LANES-1:0] keep_out;
  logic             last_out;
  logic             ready_out;
`ifdef STREAM_PACKER_STATS_EN
  logic [15:0]      frame_count;
`endif

  typedef struct {
    logic [WW-1:0]    data;
    logic [LANES-1:0] keep;
    logic             last;
  } word_t;

  word_t            exp_q[$];
  logic [DATAW-1:0] cur_q[$];
  word_t            mw;
  int               rd_ptr = 0;
  int               checks = 0;
  int               errors = 0;
  int               cyc    = 0;
  int               vcnt   = 0;

  stream_packer #(.DATAW(DATAW), .LANES(LANES)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .last_in   (last_in),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .keep_out  (keep_out),
    .last_out  (last_out),
`ifdef STREAM_PACKER_STATS_EN
    .frame_count (frame_count),
`endif
    .ready_out (ready_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: collect accepted beats into frames-of-words
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q.delete();
    end else if (valid_in && ready_in) begin
      cur_q.push_back(data_in);
      if (cur_q.size() == LANES || last_in) begin
        mw.data = '0;
        for (int i = 0; i < cur_q.size(); i++) mw.data[i*DATAW +: DATAW] = cur_q[i];
        mw.keep = LANES'((1 << cur_q.size()) - 1);
        mw.last = last_in;
        exp_q.push_back(mw);
        cur_q.delete();
      end
    end
  end

  // Monitor: compare each popped word against the next expected one
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr = exp_q.size();
    end else begin
      if (valid_out) vcnt++;
      if (valid_out && ready_out) begin
        if (rd_ptr >= exp_q.size()) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got data 0x%0h keep 0x%0h with none expected", data_out, keep_out);
        end else begin
          check("sb_data", data_out, exp_q[rd_ptr].data);
          check("sb_keep", keep_out, exp_q[rd_ptr].keep);
          check("sb_last", last_out, exp_q[rd_ptr].last);
          rd_ptr++;
        end
      end
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Present one beat (caller is just after a rising edge) and wait for acceptance
  task automatic send(input logic [DATAW-1:0] d, input logic l);
    bit ok = 1'b0;
    valid_in = 1'b1;
    data_in  = d;
    last_in  = l;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ready_in) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    last_in  = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: beat 0x%0h not accepted within 200 cycles", d);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int c0;
    int v0;
    bit done;
    valid_in  = 1'b0;
    data_in   = '0;
    last_in   = 1'b0;
    ready_out = 1'b1;
    rst_n     = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", valid_out, 1'b0);
    check("rst_data", data_out, '0);
    check("rst_keep", keep_out, '0);
    check("rst_last", last_out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    align();
    check("rst_ready_in", ready_in, 1'b1);

    // Full word
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b1);
    @(negedge clk);
    check("full_valid", valid_out, 1'b1);
    check("full_data", data_out, 32'h44332211);
    check("full_keep", keep_out, 4'b1111);
    check("full_last", last_out, 1'b1);
    @(negedge clk);
    check("full_valid_one_cycle", valid_out, 1'b0);

    // Short frame
    align();
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b1);
    @(negedge clk);
    check("short_data", data_out, 32'h0000A2A1);
    check("short_keep", keep_out, 4'b0011);
    check("short_last", last_out, 1'b1);

    // Back-pressure: 5 stalled cycles after the first word completes
    align();
    ready_out = 1'b0;
    fork
      begin
        for (int i = 1; i <= 8; i++) send(DATAW'(i), i == 8);
      end
      begin
        int n = 0;
        while (!valid_out && n < 50) begin
          @(negedge clk);
          n++;
        end
        check("bp_first_valid", valid_out, 1'b1);
        for (int s = 0; s < 5; s++) begin
          if (s > 0) @(negedge clk);
          check("bp_ready_in_low", ready_in, 1'b0);
          check("bp_data_held", data_out, 32'h04030201);
        end
        align();
        ready_out = 1'b1;
      end
    join
    @(negedge clk);
    check("bp_second_data", data_out, 32'h08070605);
    check("bp_second_keep", keep_out, 4'b1111);

    // Continuous 12-beat stream with simultaneous pop and complete
    align();
    c0 = cyc;
    v0 = vcnt;
    for (int i = 0; i < 12; i++) send(DATAW'(8'h30 + i), i == 11);
    check("stream_no_stall_cycles", cyc - c0, 12);
    repeat (2) align();
    check("stream_word_count", vcnt - v0, 3);

    // Reset while a word is held: valid_out drops immediately
    ready_out = 1'b0;
    for (int i = 0; i < 4; i++) send(DATAW'(8'hD1 + i), i == 3);
    check("held_before_reset", valid_out, 1'b1);
    rst_n = 1'b0;
    #1;
    check("reset_clears_valid", valid_out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ready_out = 1'b1;

    // Reset mid-frame: partial word discarded
    align();
    send(8'hB1, 1'b0);
    send(8'hB2, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midframe_reset_valid", valid_out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    align();
    v0 = vcnt;
    for (int i = 0; i < 4; i++) send(DATAW'(8'hC1 + i), i == 3);
    @(negedge clk);
    check("after_reset_data", data_out, 32'hC4C3C2C1);
    check("after_reset_keep", keep_out, 4'b1111);
    align();
    check("after_reset_one_word", vcnt - v0, 1);

    // Randomized traffic with random back-pressure and idle gaps
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          repeat ($urandom_range(0, 2)) align();
          send(DATAW'($urandom), $urandom_range(0, 5) == 0);
        end
        done = 1'b1;
      end
      begin
        for (int n = 0; n < 20000 && !done; n++) begin
          align();
          ready_out = ($urandom_range(0, 3) != 0);
        end
      end
    join
    ready_out = 1'b1;
    send(DATAW'($urandom), 1'b1);
    repeat (3) align();

`ifdef STREAM_PACKER_STATS_EN
    // Frame counter wrap
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    align();
    check("stats_reset", frame_count, 16'h0000);
    for (int i = 0; i < 65536; i++) send(DATAW'(i), 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("stats_wrap", frame_count, 16'h0000);
    align();
    send(8'h5A, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("stats_after_wrap", frame_count, 16'h0001);
    align();
`endif

    check("all_words_drained", rd_ptr, exp_q.size());
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
